micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Instruction-level sequencer that produces the microinstruction word (ctrl), destination select (Tgt1) and source select (Tgt2) consumed by the Controller.
- Paced by the one-hot beat ring T[7:0] from SG.
- Runs a fetch / execute machine-cycle loop. Each machine cycle is T[0]..T[7].
- Decodes the latched instruction into one ctrl word per machine cycle. Sits between the instruction register and the Controller.

Parameters:
- CTRL_W, 28, microinstruction word width.
- TGT_W, 4, one-hot register-select width (R0..R3).
- MC_CYCLES, 2, execute machine cycles for MUL/DIV (min 1, max 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- T  input  8  one-hot beat from SG; T[7] = last beat of the machine cycle.
- ir  input  8  instruction register; [7:4] opcode, [3:2] dst reg, [1:0] src reg.
- ctrl  output  28  microinstruction word to the Controller.
- Tgt1  output  4  one-hot destination select.
- Tgt2  output  4  one-hot source select (0 for unary/no-operand ops).
- fetch  output  1  high while the fetch word is driven.
- halted  output  1  sticky high after HLT.

Behaviour:
- Boundary: a rising clk edge sampled with T[7]==1. All state and outputs are registered and change only at a boundary, so each new word is stable from T[0] of the next machine cycle.
- T==0 (SG held in reset) means no boundary; everything holds.
- Reset (rst==0, asynchronous, also mid-cycle):
  - ctrl=0, Tgt1=0, Tgt2=0, fetch=0, halted=0.
  - State IDLE, hold counter 0, ir_q 0.
- State IDLE: outputs zero. At the next boundary go to FETCH.
- State FETCH:
  - ctrl = 1<<CTRL_FETCH, Tgt1=Tgt2=0, fetch=1.
  - At the boundary, latch ir into ir_q.
  - Opcode F (HLT) goes to HALT; any other opcode goes to EXEC.
- State EXEC:
  - ctrl = micro_rom(ir_q[7:4]); Tgt1 = 1<<ir_q[3:2].
  - Tgt2 = 1<<ir_q[1:0] for two-operand ops (MOV, ADD, SUB, MUL, DIV, AND, OR); Tgt2 = 0 otherwise.
  - At the boundary: MUL/DIV with MC_CYCLES>1 go to HOLD with counter=1; all other ops go to FETCH.
- State HOLD:
  - ctrl, Tgt1 and Tgt2 are unchanged.
  - Each boundary increments the counter. When counter==MC_CYCLES-1 at a boundary, go to FETCH.
- State HALT: ctrl=0, Tgt=0, halted=1. Left only by reset; T activity is ignored.
- Opcode map:
  - 0 NOP (ctrl=0, Tgt=0), 1 MOV, 2 ADD, 3 SUB, 4 MUL, 5 DIV.
  - 6 INC, 7 DEC, 8 AND, 9 OR, A NOT, B JMP, C JE, D LD, E ST, F HLT.
  - JMP/JE/NOP drive Tgt1=0.
- Each opcode sets exactly one ctrl bit, so ctrl is zero or one-hot.
- T with several bits set: the boundary is determined by T[7] alone.

Optional Feature:
- Macro: BEAT_CHECK_EN.
- Defined:
  - Adds output beat_err (1 bit, reset 0).
  - beat_err sets sticky at any clk edge where T is nonzero and not one-hot, or where T is not the rotate-left of the previous nonzero T.
  - Cleared only by reset. Sequencing is unaffected.
- Undefined: no beat_err port and no checking logic.

Decomposition:
- Package seq_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - ctrl bit indices CTRL_FETCH=0, CTRL_INC=9, CTRL_ADD=12, CTRL_MOV=15, CTRL_JMP=25, plus remaining CTRL_* for the other opcodes (unique, <28);
  - state encoding IDLE/FETCH/EXEC/HOLD/HALT.
- One sub-module micro_rom: combinational opcode[3:0] -> ctrl[27:0] plus a two-operand flag.

Test Plan:
- Reset release with ir=8'h16 (MOV R1,R2):
  - machine cycle 1 IDLE (ctrl=0);
  - cycle 2 ctrl=28'h0000001, fetch=1;
  - cycle 3 ctrl=28'h0008000, Tgt1=4'b0010, Tgt2=4'b0100.
- ir=8'h64 (INC R1) -> EXEC word 28'h0000200, Tgt1=4'b0010, Tgt2=0, then FETCH word in the next cycle.
- ir=8'h41 (MUL R0,R1), MC_CYCLES=2 -> identical MUL word for two machine cycles, then fetch=1.
- ir=8'hF0 -> after FETCH, ctrl=0 and halted=1 persist for 5+ machine cycles; rst low then high returns to IDLE, halted=0.
- rst asserted at beat T[3] of EXEC -> outputs 0 immediately, without waiting for a clk edge.
- With BEAT_CHECK_EN, drive T=8'b00000011 -> beat_err=1 and sticky; sequence advance still follows T[7].

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcodes, ctrl bit indices and state encoding for micro_sequencer.
// Build option: BEAT_CHECK_EN adds the beat_err monitor to the top.
package seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JE  = 4'hC;
  localparam logic [3:0] OP_LD  = 4'hD;
  localparam logic [3:0] OP_ST  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CTRL_FETCH = 0;
  localparam int CTRL_INC   = 9;
  localparam int CTRL_DEC   = 10;
  localparam int CTRL_NOT   = 11;
  localparam int CTRL_ADD   = 12;
  localparam int CTRL_SUB   = 13;
  localparam int CTRL_MOV   = 15;
  localparam int CTRL_MUL   = 16;
  localparam int CTRL_DIV   = 17;
  localparam int CTRL_AND   = 18;
  localparam int CTRL_OR    = 19;
  localparam int CTRL_LD    = 20;
  localparam int CTRL_ST    = 21;
  localparam int CTRL_JMP   = 25;
  localparam int CTRL_JE    = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HOLD,
    S_HALT
  } state_t;

endpackage

// File: rtl/micro_rom.sv
// Opcode to one-hot microinstruction decode.
// Also flags the ops that read a source register.
module micro_rom
  import seq_pkg::*;
#(
  parameter int CTRL_W = 28
) (
  input  logic [3:0]        op,
  output logic [CTRL_W-1:0] ctrl,
  output logic              two_op
);

  always_comb begin
    ctrl   = '0;
    two_op = 1'b0;
    case (op)
      OP_MOV: begin ctrl[CTRL_MOV] = 1'b1; two_op = 1'b1; end
      OP_ADD: begin ctrl[CTRL_ADD] = 1'b1; two_op = 1'b1; end
      OP_SUB: begin ctrl[CTRL_SUB] = 1'b1; two_op = 1'b1; end
      OP_MUL: begin ctrl[CTRL_MUL] = 1'b1; two_op = 1'b1; end
      OP_DIV: begin ctrl[CTRL_DIV] = 1'b1; two_op = 1'b1; end
      OP_AND: begin ctrl[CTRL_AND] = 1'b1; two_op = 1'b1; end
      OP_OR:  begin ctrl[CTRL_OR]  = 1'b1; two_op = 1'b1; end
      OP_INC: ctrl[CTRL_INC] = 1'b1;
      OP_DEC: ctrl[CTRL_DEC] = 1'b1;
      OP_NOT: ctrl[CTRL_NOT] = 1'b1;
      OP_JMP: ctrl[CTRL_JMP] = 1'b1;
      OP_JE:  ctrl[CTRL_JE]  = 1'b1;
      OP_LD:  ctrl[CTRL_LD]  = 1'b1;
      OP_ST:  ctrl[CTRL_ST]  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Fetch/execute micro-sequencer paced by the T[7:0] beat ring.
// Build option: BEAT_CHECK_EN adds the sticky beat_err output.
module micro_sequencer
  import seq_pkg::*;
#(
  parameter int CTRL_W    = 28,
  parameter int TGT_W     = 4,
  parameter int MC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        T,
  input  logic [7:0]        ir,
  output logic [CTRL_W-1:0] ctrl,
  output logic [TGT_W-1:0]  Tgt1,
  output logic [TGT_W-1:0]  Tgt2,
  output logic              fetch,
  output logic              halted
`ifdef BEAT_CHECK_EN
  ,
  output logic              beat_err
`endif
);

  localparam logic [TGT_W-1:0] ONE = {{(TGT_W-1){1'b0}}, 1'b1};

  state_t            st, st_n;
  logic [1:0]        cnt, cnt_n;
  logic [3:0]        op_q, op_n;
  logic [CTRL_W-1:0] ctrl_n, rom_ctrl;
  logic [TGT_W-1:0]  t1_n, t2_n;
  logic              fetch_n, halted_n;
  logic              two_op, to_fetch;

  // Decode the live ir so the EXEC word is ready at the FETCH boundary.
  micro_rom #(.CTRL_W(CTRL_W)) u_rom (
    .op     (ir[7:4]),
    .ctrl   (rom_ctrl),
    .two_op (two_op)
  );

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    op_n     = op_q;
    ctrl_n   = ctrl;
    t1_n     = Tgt1;
    t2_n     = Tgt2;
    fetch_n  = fetch;
    halted_n = halted;
    to_fetch = 1'b0;
    if (T[7]) begin
      case (st)
        S_IDLE: to_fetch = 1'b1;
        S_FETCH: begin
          op_n    = ir[7:4];
          fetch_n = 1'b0;
          if (ir[7:4] == OP_HLT) begin
            st_n     = S_HALT;
            ctrl_n   = '0;
            t1_n     = '0;
            t2_n     = '0;
            halted_n = 1'b1;
          end else begin
            st_n   = S_EXEC;
            ctrl_n = rom_ctrl;
            t1_n   = (ir[7:4] inside {OP_NOP, OP_JMP, OP_JE})
                   ? '0 : ONE << ir[3:2];
            t2_n   = two_op ? ONE << ir[1:0] : '0;
          end
        end
        S_EXEC: begin
          if ((op_q inside {OP_MUL, OP_DIV}) && MC_CYCLES > 1) begin
            st_n  = S_HOLD;
            cnt_n = 2'd1;
          end else begin
            to_fetch = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == 2'(MC_CYCLES - 1)) to_fetch = 1'b1;
          else cnt_n = cnt + 2'd1;
        end
        default: ;
      endcase
    end
    if (to_fetch) begin
      st_n               = S_FETCH;
      cnt_n              = 2'd0;
      ctrl_n             = '0;
      ctrl_n[CTRL_FETCH] = 1'b1;
      t1_n               = '0;
      t2_n               = '0;
      fetch_n            = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      cnt    <= 2'd0;
      op_q   <= 4'd0;
      ctrl   <= '0;
      Tgt1   <= '0;
      Tgt2   <= '0;
      fetch  <= 1'b0;
      halted <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      ctrl   <= ctrl_n;
      Tgt1   <= t1_n;
      Tgt2   <= t2_n;
      fetch  <= fetch_n;
      halted <= halted_n;
    end
  end

`ifdef BEAT_CHECK_EN
  logic [7:0] prev_t;
  logic       bad_beat;

  // A zero T is a paused ring and never counts against the rotation.
  always_comb begin
    bad_beat = 1'b0;
    if (T != 8'd0)
      bad_beat = ((T & (T - 8'd1)) != 8'd0) ||
                 ((prev_t != 8'd0) &&
                  (T != {prev_t[6:0], prev_t[7]}));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_t   <= 8'd0;
      beat_err <= 1'b0;
    end else begin
      if (bad_beat) beat_err <= 1'b1;
      if (T != 8'd0) prev_t <= T;
    end
  end
`else
  logic unused_t;
  assign unused_t = ^T[6:0];
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized bench for micro_sequencer against a per-machine-cycle word model.
// Build option: BEAT_CHECK_EN also exercises beat_err.
module tb_micro_sequencer;

  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  T   = 8'd0;
  logic [7:0]  ir  = 8'd0;
  logic [27:0] ctrl;
  logic [3:0]  Tgt1, Tgt2;
  logic        fetch, halted;
`ifdef BEAT_CHECK_EN
  logic        beat_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [27:0] c;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic        f;
    logic        h;
  } word_t;

  word_t cur;
  word_t q[$];

  micro_sequencer #(.CTRL_W(28), .TGT_W(4), .MC_CYCLES(MC)) dut (
    .clk    (clk),
    .rst    (rst),
    .T      (T),
    .ir     (ir),
    .ctrl   (ctrl),
    .Tgt1   (Tgt1),
    .Tgt2   (Tgt2),
    .fetch  (fetch),
    .halted (halted)
`ifdef BEAT_CHECK_EN
    ,
    .beat_err (beat_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic word_t obs_w();
    return {ctrl, Tgt1, Tgt2, fetch, halted};
  endfunction

  function automatic int bit_of(input logic [3:0] op);
    case (op)
      4'h1: return 15;
      4'h2: return 12;
      4'h3: return 13;
      4'h4: return 16;
      4'h5: return 17;
      4'h6: return 9;
      4'h7: return 10;
      4'h8: return 18;
      4'h9: return 19;
      4'hA: return 11;
      4'hB: return 25;
      4'hC: return 26;
      4'hD: return 20;
      4'hE: return 21;
      default: return -1;
    endcase
  endfunction

  function automatic word_t exec_w(input logic [7:0] i);
    word_t w;
    logic [3:0] op;
    op = i[7:4];
    w  = '0;
    if (bit_of(op) >= 0) w.c = 28'd1 << bit_of(op);
    if (!(op inside {4'h0, 4'hB, 4'hC})) w.t1 = 4'd1 << i[3:2];
    if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9})
      w.t2 = 4'd1 << i[1:0];
    return w;
  endfunction

  function automatic logic [7:0] rand_ir();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    return {op, 4'($urandom)};
  endfunction

  task automatic model_reset();
    cur = '0;
    q.delete();
  endtask

  // One machine cycle T[0]..T[7]; checks the word at T[0] and mid-cycle.
  task automatic mc(input logic [7:0] iv, output word_t o);
    word_t nx;
    int    n;
    @(negedge clk);
    o = obs_w();
    n_vec++;
    if (o !== cur) begin
      n_bad++;
      $display("FAIL mc_t0 ir=%h got %h want %h", iv, o, cur);
    end
    T  = 8'h01;
    ir = iv;
    for (int b = 1; b < 8; b++) begin
      @(negedge clk);
      if (b == 4) begin
        n_vec++;
        if (obs_w() !== cur) begin
          n_bad++;
          $display("FAIL mc_mid ir=%h got %h want %h", iv, obs_w(), cur);
        end
      end
      T = 8'(1 << b);
    end
    if (cur.h) begin
      nx = cur;
    end else if (cur.f) begin
      if (iv[7:4] == 4'hF) begin
        nx   = '0;
        nx.h = 1'b1;
      end else begin
        n = (iv[7:4] inside {4'h4, 4'h5}) ? MC : 1;
        repeat (n) q.push_back(exec_w(iv));
        nx = q.pop_front();
      end
    end else if (q.size() > 0) begin
      nx = q.pop_front();
    end else begin
      nx   = '0;
      nx.c = 28'd1;
      nx.f = 1'b1;
    end
    cur = nx;
  endtask

  task automatic run_to_fetch();
    word_t o;
    for (int k = 0; k < 8 && !cur.f; k++) mc(rand_ir(), o);
    n_vec++;
    if (cur.f !== 1'b1) begin
      n_bad++;
      $display("FAIL run_to_fetch got %b want 1", cur.f);
    end
  endtask

  task automatic reset_pulse();
    T = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs_w() !== word_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", obs_w());
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    word_t o;
    mc(8'h16, o);
    mc(8'h16, o);
    n_vec++;
    if (o.f !== 1'b1 || o.c !== 28'h0000001) begin
      n_bad++;
      $display("FAIL fetch_word got %h want c=1 f=1", o);
    end
    mc(8'h64, o);
    n_vec++;
    if ({o.c, o.t1, o.t2} !== {28'h0008000, 4'b0010, 4'b0100}) begin
      n_bad++;
      $display("FAIL mov_word got %h want 0008000/2/4", {o.c, o.t1, o.t2});
    end
    mc(8'h64, o);
    mc(8'h41, o);
    n_vec++;
    if ({o.c, o.t1, o.t2} !== {28'h0000200, 4'b0010, 4'b0000}) begin
      n_bad++;
      $display("FAIL inc_word got %h want 0000200/2/0", {o.c, o.t1, o.t2});
    end
    mc(8'h41, o);
    n_vec++;
    if (o.f !== 1'b1) begin
      n_bad++;
      $display("FAIL inc_then_fetch got %b want 1", o.f);
    end
    for (int k = 0; k < MC; k++) begin
      mc(8'h00, o);
      n_vec++;
      if ({o.c, o.t1, o.t2, o.f} !== {28'h0010000, 4'b0001, 4'b0010, 1'b0}) begin
        n_bad++;
        $display("FAIL mul_word%0d got %h want 0010000/1/2/0",
                 k, {o.c, o.t1, o.t2, o.f});
      end
    end
    mc(8'h00, o);
    n_vec++;
    if (o.f !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_then_fetch got %b want 1", o.f);
    end
  endtask

  task automatic test_random();
    word_t o;
    for (int k = 0; k < 300; k++) mc(rand_ir(), o);
  endtask

  task automatic test_t_zero();
    @(negedge clk);
    T = 8'd0;
    n_vec++;
    if (obs_w() !== cur) begin
      n_bad++;
      $display("FAIL tzero_enter got %h want %h", obs_w(), cur);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (obs_w() !== cur) begin
      n_bad++;
      $display("FAIL tzero_hold got %h want %h", obs_w(), cur);
    end
  endtask

  task automatic test_async_reset();
    word_t o;
    run_to_fetch();
    mc(8'h2B, o);
    @(negedge clk);
    n_vec++;
    if (obs_w() !== cur) begin
      n_bad++;
      $display("FAIL exec_before_rst got %h want %h", obs_w(), cur);
    end
    T = 8'h01;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      T = 8'(1 << b);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (obs_w() !== word_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset got %h want 0", obs_w());
    end
    reset_pulse();
    for (int k = 0; k < 4; k++) mc(rand_ir(), o);
  endtask

  task automatic test_halt();
    word_t o;
    run_to_fetch();
    mc(8'hF0, o);
    for (int k = 0; k < 6; k++) begin
      mc({4'($urandom), 4'($urandom)}, o);
      n_vec++;
      if ({o.c, o.t1, o.t2, o.h} !== {28'd0, 4'd0, 4'd0, 1'b1}) begin
        n_bad++;
        $display("FAIL halt_hold%0d got %h want halted word", k, o);
      end
    end
    @(negedge clk);
    T = 8'h01;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_clear got %b want 0", halted);
    end
    reset_pulse();
    mc(8'h16, o);
    mc(8'h16, o);
    mc(8'h16, o);
  endtask

`ifdef BEAT_CHECK_EN
  task automatic test_beat_err();
    word_t o;
    @(negedge clk);
    T = 8'd0;
    n_vec++;
    if (beat_err !== 1'b0) begin
      n_bad++;
      $display("FAIL beat_err_clean got %b want 0", beat_err);
    end
    @(negedge clk);
    T = 8'b0000_0011;
    @(negedge clk);
    T = 8'd0;
    n_vec++;
    if (beat_err !== 1'b1) begin
      n_bad++;
      $display("FAIL beat_err_set got %b want 1", beat_err);
    end
    for (int k = 0; k < 5; k++) mc(rand_ir(), o);
    @(negedge clk);
    T = 8'd0;
    n_vec++;
    if (beat_err !== 1'b1) begin
      n_bad++;
      $display("FAIL beat_err_sticky got %b want 1", beat_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_t_zero();
    test_random();
    test_async_reset();
    test_halt();
`ifdef BEAT_CHECK_EN
    test_beat_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
